frame_assembler: RTL
====================

Name: frame_assembler

Overview:
- Parametrised successor to the UART command-capture control: assembles a command frame from the UART RX byte stream. Frame format: one opcode byte, then NUM_OPERANDS operands of DATA_W bits each, sent MSB byte first.
- Completed frames are committed atomically to the output registers with a one-cycle frame_valid strobe.
- An inter-byte timeout and frame_error strobe are added so a lost byte cannot desynchronise the stream.
- Sits between the UART receiver and the ALU/execution stage.

Parameters:
- DATA_W, 8, operand width in bits; must be a multiple of 8, range 8..32.
- NUM_OPERANDS, 2, operands per frame; range 1..4.
- TIMEOUT_CYCLES, 50000, max clk cycles between bytes inside a frame (1 ms at 50 MHz); 0 disables the timeout.

Ports:
- clk  input  1  system clock, 50 MHz, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data_ready  input  1  one-cycle strobe from the UART: rx_data is valid this cycle.
- rx_data  input  8  received byte.
- operation  output  8  opcode of the last committed frame.
- data_out  output  NUM_OPERANDS*DATA_W  committed operands; operand 0 in the LSB slice [DATA_W-1:0], operand k in [(k+1)*DATA_W-1:k*DATA_W].
- frame_valid  output  1  one-cycle pulse: operation/data_out were just updated.
- frame_error  output  1  one-cycle pulse: a partial frame was discarded on timeout.
- busy  output  1  high while a frame is partially received.

Behaviour:
- Reset (reset=0, asynchronous) values:
  - operation=0, data_out=0, frame_valid=0, frame_error=0, busy=0.
  - State=IDLE; byte counter, timeout counter and shadow registers all 0.
- Derived constants:
  - BPO = DATA_W/8 (bytes per operand).
  - TOTAL = NUM_OPERANDS*BPO (operand bytes per frame).
- State IDLE:
  - rx_data_ready=1 latches rx_data into the opcode shadow.
  - Clears byte_cnt and the timeout counter; goes to RECV.
- State RECV, on rx_data_ready=1:
  - The byte is written into the operand shadow at operand byte_cnt/BPO.
  - Byte position within the operand is BPO-1-(byte_cnt mod BPO), so the first byte lands in the MSB.
  - byte_cnt increments and the timeout counter clears.
- Commit, on the rising edge that captures byte TOTAL-1:
  - operation<=opcode shadow; data_out<=operand shadow with that byte merged in the same edge.
  - frame_valid=1 for exactly the following cycle; state returns to IDLE.
- Latency: last operand byte strobe in cycle N gives outputs updated and frame_valid=1 in cycle N+1.
  - A strobe in cycle N+1 is accepted as the opcode of the next frame; back-to-back frames lose no byte.
- Output stability: operation/data_out change only on commit. They hold the last committed frame indefinitely, including through timeouts and partial frames.
- Timeout (TIMEOUT_CYCLES>0), in RECV with no strobe:
  - The timeout counter increments each cycle.
  - On reaching TIMEOUT_CYCLES: shadows are discarded, frame_error=1 for one cycle, state returns to IDLE, outputs are untouched.
  - A strobe arriving in the same cycle the counter would expire wins: the byte is accepted and the counter cleared.
- The timeout counter is idle and held at 0 in IDLE.
- busy=1 exactly while in RECV; it is registered, so it rises the cycle after the opcode strobe.
- frame_valid and frame_error are never high in the same cycle.
- Reset asserted mid-frame: immediate return to the reset values. No frame_valid or frame_error is generated; the partial frame is lost.
- Counter widths: byte_cnt is $clog2(TOTAL+1) bits; the timeout counter is $clog2(TIMEOUT_CYCLES+1) bits (minimum 1). No wrap is possible within the legal ranges.
- rx_data is ignored whenever rx_data_ready=0.

Test Plan:
- Defaults (8/2), bytes 0x03,0x12,0x34 spaced 10 cycles -> cycle after 0x34: operation=0x03, data_out=0x3412, frame_valid one cycle; busy high from after 0x03 until commit.
- DATA_W=16, NUM_OPERANDS=2, bytes 0xA5,0x12,0x34,0x56,0x78 -> operation=0xA5, data_out=0x56781234, single frame_valid.
- Back-to-back, bytes strobed on consecutive cycles 0x01,0xAA,0xBB,0x02,0xCC,0xDD -> two frame_valid pulses 3 cycles apart; final operation=0x02, data_out=0xDDCC.
- TIMEOUT_CYCLES=20, send 0x07,0x11 then silence -> frame_error pulses 20 cycles after 0x11, outputs keep the prior frame. Then send 0x04,0x55,0x66 -> operation=0x04, data_out=0x6655.
- TIMEOUT_CYCLES=20, next byte strobed exactly on cycle 20 after the previous one -> accepted, no frame_error, frame completes normally.
- Assert reset=0 asynchronously after 0x09,0x77 (mid-clock) -> all outputs 0 immediately. After release, frame 0x05,0x01,0x02 -> data_out=0x0201, no stale 0x77.

Source files
------------

// File: rtl/frame_assembler.sv
// -----------------------------------------------------------------------------
// frame_assembler
//
// Assembles a command frame from a UART RX byte stream and hands it to the
// execution stage. A frame is one opcode byte followed by NUM_OPERANDS operands
// of DATA_W bits each. Each operand is sent MSB byte first. A completed frame is
// committed to the outputs in a single edge, and a one-cycle frame_valid strobe
// marks that edge. An inter-byte timeout drops a partial frame and pulses
// frame_error. This keeps a lost byte from shifting every later frame.
//
// Parameters
//   DATA_W          operand width in bits, multiple of 8, 8..32
//   NUM_OPERANDS    operands per frame, 1..4
//   TIMEOUT_CYCLES  max clk cycles between bytes inside a frame (0 = disabled)
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-low reset
//   rx_data_ready  in   one-cycle strobe: rx_data is valid this cycle
//   rx_data        in   received byte
//   operation      out  opcode of the last committed frame
//   data_out       out  committed operands, operand k in [(k+1)*DATA_W-1:k*DATA_W]
//   frame_valid    out  one-cycle pulse: operation/data_out were just updated
//   frame_error    out  one-cycle pulse: a partial frame was discarded on timeout
//   busy           out  high while a frame is partially received
// -----------------------------------------------------------------------------
module frame_assembler #(
  parameter int DATA_W         = 8,
  parameter int NUM_OPERANDS   = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx_data_ready,
  input  logic [7:0]                     rx_data,
  output logic [7:0]                     operation,
  output logic [NUM_OPERANDS*DATA_W-1:0] data_out,
  output logic                           frame_valid,
  output logic                           frame_error,
  output logic                           busy
);

  localparam int BPO     = DATA_W / 8;          // bytes per operand
  localparam int TOTAL   = NUM_OPERANDS * BPO;  // operand bytes per frame
  localparam int FRAME_W = NUM_OPERANDS * DATA_W;
  localparam int CNT_W   = $clog2(TOTAL + 1);
  localparam int TO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [7:0]         r_op_shadow;
  logic [FRAME_W-1:0] r_opnd_shadow;
  logic [CNT_W-1:0]   r_byte_cnt;
  logic [TO_W-1:0]    r_to_cnt;

  logic [7:0]         r_operation;
  logic [FRAME_W-1:0] r_data_out;
  logic               r_frame_valid;
  logic               r_frame_error;

  logic               w_accept_op;
  logic               w_accept_byte;
  logic               w_commit;
  logic               w_timeout;
  logic               w_to_expire;
  logic [FRAME_W-1:0] w_opnd_merged;

  // The counter expires on the edge where it would reach TIMEOUT_CYCLES. A
  // strobe in that same cycle wins, because the FSM tests rx_data_ready first.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      assign w_to_expire = ((r_to_cnt + TO_W'(1)) == TO_W'(TIMEOUT_CYCLES));
    end else begin : g_no_timeout
      assign w_to_expire = 1'b0;
    end
  endgenerate

  // Operand shadow with the current byte merged in. The first byte of each
  // operand goes to its MSB slot. The commit edge uses this value directly,
  // so the last byte appears in data_out without waiting an extra cycle.
  always_comb begin
    w_opnd_merged = r_opnd_shadow;
    for (int b = 0; b < TOTAL; b++) begin
      if (r_byte_cnt == CNT_W'(b)) begin
        w_opnd_merged[((b / BPO) * BPO + (BPO - 1 - (b % BPO))) * 8 +: 8] = rx_data;
      end
    end
  end

  // Next-state and control decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can hold
    // an old value and infer a latch.
    w_state_nxt   = r_state;
    w_accept_op   = 1'b0;
    w_accept_byte = 1'b0;
    w_commit      = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_data_ready) begin
          w_accept_op = 1'b1;
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_data_ready) begin
          w_accept_byte = 1'b1;
          if (r_byte_cnt == CNT_W'(TOTAL - 1)) begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_to_expire) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples its pre-edge inputs, whatever the order of
    // the statements.
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath: shadows, counters and committed outputs.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the shadows are plain flops, not a memory array. Resetting them is
    // cheap, and it guarantees that a frame cut short by reset leaves no
    // stale bytes behind.
    if (!reset) begin
      r_op_shadow   <= '0;
      r_opnd_shadow <= '0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
      r_operation   <= '0;
      r_data_out    <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_frame_valid <= w_commit;
      r_frame_error <= w_timeout;
      if (w_commit) begin
        r_operation   <= r_op_shadow;
        r_data_out    <= w_opnd_merged;
        r_op_shadow   <= '0;
        r_opnd_shadow <= '0;
        r_byte_cnt    <= '0;
        r_to_cnt      <= '0;
      end else if (w_accept_byte) begin
        r_opnd_shadow <= w_opnd_merged;
        r_byte_cnt    <= r_byte_cnt + CNT_W'(1);
        r_to_cnt      <= '0;
      end else if (w_accept_op) begin
        r_op_shadow   <= rx_data;
        r_opnd_shadow <= '0;
        r_byte_cnt    <= '0;
        r_to_cnt      <= '0;
      end else if (w_timeout) begin
        r_op_shadow   <= '0;
        r_opnd_shadow <= '0;
        r_byte_cnt    <= '0;
        r_to_cnt      <= '0;
      end else if (r_state == S_RECV && TIMEOUT_CYCLES > 0) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end
  end

  assign operation   = r_operation;
  assign data_out    = r_data_out;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign busy        = (r_state == S_RECV);

endmodule
